// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared CPU constants for the sequential divider (width, FSM states, ALU op codes).
package div_seq_pkg;
  localparam int DATA_W = 32;
  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;
  typedef enum logic [1:0] {
    DIV_FREE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } div_state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract iteration on magnitudes.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);
  logic [W:0] shf, dif;
  logic       ge;
  // rem_i < dvs_i always holds, so dif[W] alone is the borrow of the trial subtract
  assign shf   = {rem_i, quo_i[W-1]};
  assign dif   = shf - {1'b0, dvs_i};
  assign ge    = ~dif[W];
  assign rem_o = ge ? dif[W-1:0] : shf[W-1:0];
  assign quo_o = {quo_i[W-2:0], ge};
endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle div/divu unit with annul, divide-by-zero path and held result handshake.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = div_seq_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);
  localparam int CW = $clog2(DATA_W) + 1;
  div_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [DATA_W-1:0] rem_nxt, quo_nxt, a_mag, b_mag, q_fix, r_fix;
  logic sdiv_q, sdiv_d, a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic ready_q, ready_d;
  div_step #(.W(DATA_W)) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .dvs_i(dvs_q),
    .rem_o(rem_nxt),
    .quo_o(quo_nxt)
  );
  assign a_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign b_mag = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  assign q_fix = (sdiv_q && (a_neg_q ^ b_neg_q)) ? -quo_nxt : quo_nxt;
  assign r_fix = (sdiv_q && a_neg_q) ? -rem_nxt : rem_nxt;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    sdiv_d   = sdiv_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      DIV_FREE: if (start_i && !annul_i) begin
        state_d = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
        cnt_d   = '0;
        rem_d   = '0;
        quo_d   = a_mag;
        dvs_d   = b_mag;
        sdiv_d  = signed_div_i;
        a_neg_d = signed_div_i & opdata1_i[DATA_W-1];
        b_neg_d = signed_div_i & opdata2_i[DATA_W-1];
      end
      DIV_BYZERO: begin
        state_d  = DIV_END;
        result_d = '0;
        ready_d  = 1'b1;
      end
      DIV_ON: if (annul_i) begin
        state_d  = DIV_FREE;
        result_d = '0;
        ready_d  = 1'b0;
      end else begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_W - 1)) begin
          state_d  = DIV_END;
          result_d = {r_fix, q_fix};
          ready_d  = 1'b1;
        end
      end
      DIV_END: if (!start_i) begin
        state_d  = DIV_FREE;
        result_d = '0;
        ready_d  = 1'b0;
      end
      default: state_d = DIV_FREE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sdiv_q   <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      sdiv_q   <= sdiv_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end
  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q == DIV_ON) || (state_q == DIV_BYZERO);
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scenario tasks driving div_seq with a queue of expected results from an arithmetic model.
module tb_div_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_i = 1'b0, annul_i = 1'b0, signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0, opdata2_i = '0;
  logic [63:0] result_o;
  logic        ready_o, busy_o;
  int checks = 0, errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_v, obs_res, obs_hold, obs_rel_res;
  int obs_lat, obs_busy;
  logic obs_end_busy, obs_hold_rdy, obs_rel_rdy;

  div_seq dut (
    .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
    .signed_div_i(signed_div_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 0) return '0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Drives one divide, scrambles operands while busy, holds one extra END cycle with annul, then releases.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1; annul_i = 1'b0;
    @(posedge clk); #1;
    obs_busy = 0; obs_lat = -1;
    for (int k = 1; k <= 100 && obs_lat < 0; k++) begin
      obs_busy += int'(busy_o);
      opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'($urandom);
      @(posedge clk); #1;
      if (ready_o) obs_lat = k;
    end
    obs_res = result_o; obs_end_busy = busy_o;
    annul_i = 1'b1;
    @(posedge clk); #1;
    obs_hold = result_o; obs_hold_rdy = ready_o;
    annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    obs_rel_rdy = ready_o; obs_rel_res = result_o;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if (result_o !== 64'd0 || ready_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got res=%h rdy=%b busy=%b, want 0/0/0", result_o, ready_o, busy_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd10; opdata2_i = 32'd2;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL annul_priority_free: busy=%b want 0", busy_o); end
    end
    start_i = 1'b0; annul_i = 1'b0;
  endtask

  task automatic test_divu_basic();
    exp_q.push_back(model(1'b0, 32'd100, 32'd7));
    do_div(1'b0, 32'd100, 32'd7);
    exp_v = exp_q.pop_front();
    checks++;
    if (exp_v !== 64'h00000002_0000000E) begin errors++; $display("FAIL divu100_model: got %h want 00000002_0000000e", exp_v); end
    checks++;
    if (obs_lat !== 32) begin errors++; $display("FAIL divu100_latency: got %0d want 32", obs_lat); end
    checks++;
    if (obs_busy !== 32) begin errors++; $display("FAIL divu100_busy_cycles: got %0d want 32", obs_busy); end
    checks++;
    if (obs_res !== exp_v) begin errors++; $display("FAIL divu100_result: got %h want %h", obs_res, exp_v); end
    checks++;
    if (obs_end_busy !== 1'b0) begin errors++; $display("FAIL divu100_end_busy: got %b want 0", obs_end_busy); end
    checks++;
    if (obs_hold !== exp_v || obs_hold_rdy !== 1'b1) begin
      errors++; $display("FAIL divu100_end_hold: got %h rdy=%b want %h rdy=1", obs_hold, obs_hold_rdy, exp_v);
    end
    checks++;
    if (obs_rel_rdy !== 1'b0 || obs_rel_res !== 64'd0) begin
      errors++; $display("FAIL divu100_release: got %h rdy=%b want 0 rdy=0", obs_rel_res, obs_rel_rdy);
    end
  endtask

  task automatic test_signed();
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
    do_div(1'b1, 32'hFFFFFFF9, 32'h00000002);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs_res !== exp_v || obs_lat !== 32) begin
      errors++; $display("FAIL div_m7_2: got %h lat=%0d want %h lat=32", obs_res, obs_lat, exp_v);
    end
    exp_q.push_back(64'h00000000_80000000);
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs_res !== exp_v || obs_lat !== 32) begin
      errors++; $display("FAIL div_min_m1: got %h lat=%0d want %h lat=32", obs_res, obs_lat, exp_v);
    end
    exp_q.push_back(model(1'b1, 32'd7, 32'hFFFFFFFE));
    do_div(1'b1, 32'd7, 32'hFFFFFFFE);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs_res !== exp_v) begin errors++; $display("FAIL div_7_m2: got %h want %h", obs_res, exp_v); end
  endtask

  task automatic test_byzero();
    exp_q.push_back(64'd0);
    do_div(1'b1, 32'd5, 32'd0);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs_lat !== 1 || obs_busy !== 1) begin
      errors++; $display("FAIL byzero_latency: got lat=%0d busy=%0d want 1/1", obs_lat, obs_busy);
    end
    checks++;
    if (obs_res !== exp_v || obs_hold_rdy !== 1'b1) begin
      errors++; $display("FAIL byzero_result: got %h hold_rdy=%b want %h 1", obs_res, obs_hold_rdy, exp_v);
    end
  endtask

  task automatic test_annul();
    int seen;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (10) begin @(posedge clk); #1; end
    annul_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL annul_free: got busy=%b rdy=%b res=%h want 0/0/0", busy_o, ready_o, result_o);
    end
    start_i = 1'b0; annul_i = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; seen += int'(ready_o) + int'(busy_o); end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL annul_no_ready: got %0d active samples want 0", seen); end
    exp_q.push_back(model(1'b0, 32'd9, 32'd3));
    do_div(1'b0, 32'd9, 32'd3);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs_res !== 64'h00000000_00000003 || obs_lat !== 32) begin
      errors++; $display("FAIL annul_followup: got %h lat=%0d want 0000000000000003 lat=32", obs_res, obs_lat);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd12345; opdata2_i = 32'd17; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (20) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL reset_mid_async: got busy=%b rdy=%b res=%h want 0/0/0", busy_o, ready_o, result_o);
    end
    start_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    exp_q.push_back(model(1'b0, 32'd8, 32'd2));
    do_div(1'b0, 32'd8, 32'd2);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs_res !== 64'h00000000_00000004 || obs_lat !== 32) begin
      errors++; $display("FAIL reset_mid_followup: got %h lat=%0d want 0000000000000004 lat=32", obs_res, obs_lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic s;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = (i == 3) ? 32'd0 : ((i == 5) ? 32'd1 : $urandom_range(1, 70000));
      s = 1'(i);
      if (i == 6) b = -b;
      exp_q.push_back(model(s, a, b));
      do_div(s, a, b);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_res !== exp_v || obs_lat !== ((b == 0) ? 1 : 32)) begin
        errors++; $display("FAIL b2b_%0d: s=%b %h/%h got %h lat=%0d want %h", i, s, a, b, obs_res, obs_lat, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_byzero();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the operand width; result width is 2*DATA_W.
REQ-002 SHALL have port clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  divide request from EX, held high until the result is taken.
REQ-005 SHALL have port annul_i  input  1  cancel the current or requested divide (pipeline flush).
REQ-006 SHALL have port signed_div_i  input  1  1 = div (two's complement), 0 = divu.
REQ-007 SHALL have port opdata1_i  input  DATA_W  dividend.
REQ-008 SHALL have port opdata2_i  input  DATA_W  divisor.
REQ-009 SHALL have port result_o  output  2*DATA_W  {remainder (to HI), quotient (to LO)}, registered.
REQ-010 SHALL have port ready_o  output  1  result_o is valid, registered.
REQ-011 SHALL have port busy_o  output  1  divide in progress; EX uses it as a stall request.

Function
REQ-012 SHALL implement a four-state FSM: FREE, BYZERO, ON, END.
REQ-013 In FREE with start_i=1 and annul_i=0: opdata2_i==0 -> BYZERO; otherwise -> ON, iteration counter cleared, operands latched.
REQ-014 In FREE with annul_i=1 or start_i=0, the FSM SHALL stay in FREE; annul_i has priority over start_i.
REQ-015 When signed_div_i=1, latched operands SHALL be magnitudes (negated if MSB set); the signs and signed_div_i SHALL also be latched.
REQ-016 ON SHALL perform one restoring shift-subtract step per cycle (shift partial remainder left by 1, bring in next dividend bit MSB-first, subtract if >= divisor, quotient bit = 1 on subtract).
REQ-017 Exactly DATA_W iterations SHALL be done; the edge completing iteration DATA_W SHALL move to END and register the result, so ready_o rises DATA_W cycles after the accepting edge.
REQ-018 Sign fix-up (signed only): quotient negated when operand signs differ; remainder takes the dividend's sign.
REQ-019 Signed -2^(DATA_W-1) / -1 SHALL produce quotient 0x80000000 (wrap), remainder 0, no exception.
REQ-020 annul_i=1 in ON SHALL return to FREE on the next edge; result_o stays 0 and ready_o stays 0.
REQ-021 BYZERO SHALL move to END on the next edge with result_o=0 and ready_o=1.
REQ-022 In END, result_o and ready_o SHALL hold while start_i=1; when start_i=0 the FSM SHALL go to FREE and clear ready_o and result_o on that edge.
REQ-023 annul_i in END SHALL have no effect; only start_i low releases END.
REQ-024 Changes on start_i, opdata*_i or signed_div_i during ON/BYZERO/END SHALL be ignored.
REQ-025 busy_o SHALL be 1 exactly in states ON and BYZERO; 0 in FREE and END.

Reset
REQ-026 On rst low, immediately and asynchronously: state=FREE, counter=0, result_o=0, ready_o=0, busy_o=0, latched operands=0.
REQ-027 Reset mid-operation SHALL abandon the divide; after release, the first start_i SHALL be accepted normally.

Structure
REQ-028 The shared CPU defines package SHALL hold the FSM state encodings, the div/divu ALU op codes (8'b00011010, 8'b00011011) and the DATA_W constant.
REQ-029 The per-cycle trial subtract/shift SHALL be a combinational sub-module div_step; the FSM, counter and sign fix-up SHALL remain in div_seq.

Verification
REQ-030 divu 100/7, start held: ready_o rises 32 cycles after acceptance, result_o=0x00000002_0000000E; busy_o high for those 32 cycles.
REQ-031 div -7/2 (0xFFFFFFF9/0x00000002): result_o=0xFFFFFFFF_FFFFFFFD.
REQ-032 div 5/0: BYZERO then END, ready_o high 1 cycle after acceptance, result_o=0.
REQ-033 div 0x80000000/0xFFFFFFFF: result_o=0x00000000_80000000.
REQ-034 divu 1000/3 with annul_i pulsed at iteration 10: FREE next cycle, ready_o never asserts; following divu 9/3 gives 0x00000000_00000003.
REQ-035 rst low during iteration 20: all outputs 0 before the next edge; after release divu 8/2 gives 0x00000000_00000004 with normal latency.
